// File: rtl/ro_puf_pair_counter_if.sv
// Request/result bundle between the challenge/response controller and the RO pair counter.
// The controller owns the master side; the measurement core owns the slave side.
interface ro_puf_pair_counter_if #(
    parameter int N_RO  = 8,
    parameter int SEL_W = $clog2(N_RO),
    parameter int CNT_W = 16
);
    logic             start;
    logic [SEL_W-1:0] chal_a;
    logic [SEL_W-1:0] chal_b;
    logic             busy;
    logic             done;
    logic             response;
    logic             tie;
    logic             err;
    logic [CNT_W-1:0] count_a;
    logic [CNT_W-1:0] count_b;

    modport master (
        output start, chal_a, chal_b,
        input  busy, done, response, tie, err, count_a, count_b
    );

    modport slave (
        input  start, chal_a, chal_b,
        output busy, done, response, tie, err, count_a, count_b
    );
endinterface

// File: rtl/ro_puf_pair_counter.sv
// Ring-oscillator PUF pair measurement: enables one challenge pair, lets it settle, counts
// synchronised rising edges of both oscillators over a fixed window and compares the counts.
module ro_puf_pair_counter #(
    parameter int N_RO       = 8,
    parameter int SEL_W      = $clog2(N_RO),
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 16,
    parameter int WINDOW     = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_RO-1:0]      ro_in,
    output logic [N_RO-1:0]      ro_enable,
    ro_puf_pair_counter_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_COUNT,
        S_COMPARE,
        S_DONE
    } state_t;

    localparam int               TMR_MAX     = (SETTLE_CYC > WINDOW) ? SETTLE_CYC : WINDOW;
    localparam int               TMR_W       = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] WINDOW_LOAD = TMR_W'(WINDOW - 1);
    localparam logic [SEL_W:0]   N_RO_LIM    = (SEL_W + 1)'(N_RO);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t           r_state_reg;
    state_t           w_state_next;
    logic [TMR_W-1:0] r_timer_reg;
    logic [TMR_W-1:0] w_timer_next;
    logic [SEL_W-1:0] r_sel_a_reg;
    logic [SEL_W-1:0] r_sel_b_reg;
    logic [SEL_W-1:0] w_sel_a_next;
    logic [SEL_W-1:0] w_sel_b_next;
    logic             w_chal_bad;
    logic             w_bad_start;
    logic [N_RO-1:0]  w_rise;
    logic [N_RO-1:0]  w_pair_mask;
    logic [N_RO-1:0]  r_ro_enable_reg;
    logic [N_RO-1:0]  w_ro_enable_next;
    logic [CNT_W-1:0] w_cnt [2];
    logic [SEL_W-1:0] w_sel [2];

    logic             r_response_reg;
    logic             r_tie_reg;
    logic             r_err_reg;
    logic [CNT_W-1:0] r_count_a_reg;
    logic [CNT_W-1:0] r_count_b_reg;

    // Two flops resynchronise each oscillator, the third holds last sample for edge detection.
    for (genvar gi = 0; gi < N_RO; gi++) begin : g_sync
        logic [2:0] r_sync_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync_reg <= '0;
            end else begin
                r_sync_reg <= {r_sync_reg[1:0], ro_in[gi]};
            end
        end

        assign w_rise[gi]      = r_sync_reg[1] & ~r_sync_reg[2];
        assign w_pair_mask[gi] = (w_sel_a_next == SEL_W'(gi)) || (w_sel_b_next == SEL_W'(gi));
    end

    assign w_sel[0] = r_sel_a_reg;
    assign w_sel[1] = r_sel_b_reg;

    // Channel 0 counts oscillator a, channel 1 counts oscillator b.
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        logic [CNT_W-1:0] r_cnt_reg;
        logic             w_hit;

        assign w_hit = w_rise[w_sel[gi]];

        always_ff @(posedge clk) begin
            if (rst || r_state_reg == S_SETTLE) begin
                r_cnt_reg <= '0;
            end else if (r_state_reg == S_COUNT && w_hit && r_cnt_reg != CNT_MAX) begin
                r_cnt_reg <= r_cnt_reg + CNT_W'(1);
            end
        end

        assign w_cnt[gi] = r_cnt_reg;
    end

    assign w_chal_bad = (bus.chal_a == bus.chal_b)
                     || ({1'b0, bus.chal_a} >= N_RO_LIM)
                     || ({1'b0, bus.chal_b} >= N_RO_LIM);

    always_comb begin
        w_state_next = r_state_reg;
        w_timer_next = r_timer_reg;
        w_sel_a_next = r_sel_a_reg;
        w_sel_b_next = r_sel_b_reg;
        w_bad_start  = 1'b0;
        case (r_state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    w_sel_a_next = bus.chal_a;
                    w_sel_b_next = bus.chal_b;
                    if (w_chal_bad) begin
                        w_state_next = S_DONE;
                        w_bad_start  = 1'b1;
                    end else begin
                        w_state_next = S_SETTLE;
                        w_timer_next = SETTLE_LOAD;
                    end
                end
            end
            S_SETTLE: begin
                if (r_timer_reg == '0) begin
                    w_state_next = S_COUNT;
                    w_timer_next = WINDOW_LOAD;
                end else begin
                    w_timer_next = r_timer_reg - TMR_W'(1);
                end
            end
            S_COUNT: begin
                if (r_timer_reg == '0) begin
                    w_state_next = S_COMPARE;
                end else begin
                    w_timer_next = r_timer_reg - TMR_W'(1);
                end
            end
            S_COMPARE: w_state_next = S_DONE;
            S_DONE:    w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Enables are registered so the oscillators see a glitch-free gate.
    always_comb begin
        w_ro_enable_next = '0;
        if (w_state_next == S_SETTLE || w_state_next == S_COUNT) begin
            w_ro_enable_next = w_pair_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_reg     <= S_IDLE;
            r_timer_reg     <= '0;
            r_sel_a_reg     <= '0;
            r_sel_b_reg     <= '0;
            r_ro_enable_reg <= '0;
        end else begin
            r_state_reg     <= w_state_next;
            r_timer_reg     <= w_timer_next;
            r_sel_a_reg     <= w_sel_a_next;
            r_sel_b_reg     <= w_sel_b_next;
            r_ro_enable_reg <= w_ro_enable_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_response_reg <= 1'b0;
            r_tie_reg      <= 1'b0;
            r_err_reg      <= 1'b0;
            r_count_a_reg  <= '0;
            r_count_b_reg  <= '0;
        end else if (r_state_reg == S_COMPARE) begin
            r_response_reg <= (w_cnt[0] > w_cnt[1]);
            r_tie_reg      <= (w_cnt[0] == w_cnt[1]);
            r_err_reg      <= 1'b0;
            r_count_a_reg  <= w_cnt[0];
            r_count_b_reg  <= w_cnt[1];
        end else if (w_bad_start) begin
            r_response_reg <= 1'b0;
            r_tie_reg      <= 1'b0;
            r_err_reg      <= 1'b1;
            r_count_a_reg  <= '0;
            r_count_b_reg  <= '0;
        end
    end

    assign ro_enable    = r_ro_enable_reg;
    assign bus.busy     = (r_state_reg == S_SETTLE) || (r_state_reg == S_COUNT)
                       || (r_state_reg == S_COMPARE);
    assign bus.done     = (r_state_reg == S_DONE);
    assign bus.response = r_response_reg;
    assign bus.tie      = r_tie_reg;
    assign bus.err      = r_err_reg;
    assign bus.count_a  = r_count_a_reg;
    assign bus.count_b  = r_count_b_reg;
endmodule

// File: tb/tb_ro_puf_pair_counter.sv
// Directed bench for ro_puf_pair_counter: expected results are queued at start and checked on done.
`timescale 1ns/1ps
module tb_ro_puf_pair_counter;
    localparam int N_RO = 8;
    localparam int S    = 16;
    localparam int W    = 1000;
    localparam int HP [N_RO] = '{60, 70, 80, 250, 90, 200, 110, 130};

    typedef struct {
        int          cyc;
        logic [15:0] ca;
        logic [15:0] cb;
        int          tol;
        logic        resp;
        logic        tie;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ro_a;
    logic [7:0]  en_a;
    logic [7:0]  ro_b;
    logic [7:0]  en_b;
    logic        osc50 = 1'b0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          t0;
    exp_t        q_a[$];
    exp_t        q_b[$];
    exp_t        e_a;
    exp_t        e_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < N_RO; gi++) begin : g_osc
        logic r_osc = 1'b0;
        always #(HP[gi]) r_osc = ~r_osc;
        assign ro_a[gi] = r_osc;
    end
    always #50 osc50 = ~osc50;
    assign ro_b = {8{osc50}};

    ro_puf_pair_counter_if #(.N_RO(8), .CNT_W(16)) bus_a ();
    ro_puf_pair_counter_if #(.N_RO(8), .CNT_W(4))  bus_b ();

    ro_puf_pair_counter #(.N_RO(8), .CNT_W(16), .SETTLE_CYC(S), .WINDOW(W)) dut_a (
        .clk(clk), .rst(rst), .ro_in(ro_a), .ro_enable(en_a), .bus(bus_a)
    );
    ro_puf_pair_counter #(.N_RO(8), .CNT_W(4), .SETTLE_CYC(S), .WINDOW(W)) dut_b (
        .clk(clk), .rst(rst), .ro_in(ro_b), .ro_enable(en_b), .bus(bus_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input logic [31:0] obs, input logic [31:0] exp, input int tol);
        logic ok;
        ok = (obs + tol >= exp) && (obs <= exp + tol);
        n_cmp++;
        assert (ok === 1'b1) else begin
            n_bad++;
            $error("FAIL %s: got %0d want %0d +/-%0d", tag, obs, exp, tol);
        end
    endtask

    task automatic check_entry(input string tag, input exp_t e, input int c,
                               input logic [15:0] ca, input logic [15:0] cb,
                               input logic resp, input logic tie, input logic err);
        chk({tag, ".done_cyc"}, c, e.cyc);
        chk_tol({tag, ".count_a"}, ca, e.ca, e.tol);
        chk_tol({tag, ".count_b"}, cb, e.cb, e.tol);
        chk({tag, ".response"}, resp, e.resp);
        chk({tag, ".tie"}, tie, e.tie);
        chk({tag, ".err"}, err, e.err);
        $display("done %s @%0d: count_a=%0d count_b=%0d resp=%0b tie=%0b err=%0b",
                 tag, c, ca, cb, resp, tie, err);
    endtask

    always @(negedge clk) begin
        if (bus_a.done === 1'b1) begin
            chk("A.done_expected", 32'(q_a.size() > 0), 32'd1);
            if (q_a.size() > 0) begin
                e_a = q_a.pop_front();
                check_entry("A", e_a, cyc, bus_a.count_a, bus_a.count_b,
                            bus_a.response, bus_a.tie, bus_a.err);
            end
        end
        if (bus_b.done === 1'b1) begin
            chk("B.done_expected", 32'(q_b.size() > 0), 32'd1);
            if (q_b.size() > 0) begin
                e_b = q_b.pop_front();
                check_entry("B", e_b, cyc, 16'(bus_b.count_a), 16'(bus_b.count_b),
                            bus_b.response, bus_b.tie, bus_b.err);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected counts come from the oscillator half-periods: window length / oscillator period.
    task automatic meas_a(input int a, input int b, output int ts);
        exp_t e;
        e.tol = 1;
        if (a == b || a >= N_RO || b >= N_RO) begin
            e.cyc = cyc + 1; e.ca = '0; e.cb = '0;
            e.resp = 1'b0; e.tie = 1'b0; e.err = 1'b1;
        end else begin
            e.cyc  = cyc + 1 + S + W + 1;
            e.ca   = 16'((W * 10) / (2 * HP[a]));
            e.cb   = 16'((W * 10) / (2 * HP[b]));
            e.resp = (e.ca > e.cb);
            e.tie  = (e.ca == e.cb);
            e.err  = 1'b0;
        end
        q_a.push_back(e);
        bus_a.start  = 1'b1;
        bus_a.chal_a = 3'(a);
        bus_a.chal_b = 3'(b);
        @(posedge clk);
        #1;
        ts = cyc;
        bus_a.start = 1'b0;
        $display("start A chal=(%0d,%0d) at cyc %0d", a, b, ts);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000 && (q_a.size() > 0 || q_b.size() > 0); i++) begin
            @(posedge clk);
            #1;
        end
        chk({tag, ".pending_after_timeout"}, q_a.size() + q_b.size(), 0);
        tick(2);
    endtask

    initial begin
        bus_a.start = 1'b0; bus_a.chal_a = '0; bus_a.chal_b = '0;
        bus_b.start = 1'b0; bus_b.chal_a = '0; bus_b.chal_b = '0;
        tick(3);
        chk("rst.ro_enable", en_a, 0);
        chk("rst.busy", bus_a.busy, 0);
        chk("rst.done", bus_a.done, 0);
        chk("rst.response", bus_a.response, 0);
        chk("rst.tie", bus_a.tie, 0);
        chk("rst.err", bus_a.err, 0);
        chk("rst.count_a", bus_a.count_a, 0);
        chk("rst.count_b", bus_a.count_b, 0);
        rst = 1'b0;
        tick(2);

        // Normal compare, a slower; enable pair window checked at its edges.
        meas_a(3, 5, t0);
        chk("t1.en_settle", en_a, 8'h28);
        chk("t1.busy_settle", bus_a.busy, 1);
        wait_cyc(t0 + S + W - 1);
        chk("t1.en_last_count", en_a, 8'h28);
        wait_cyc(t0 + S + W);
        chk("t1.en_compare", en_a, 0);
        chk("t1.busy_compare", bus_a.busy, 1);
        wait_idle("t1");

        meas_a(5, 3, t0);
        wait_idle("t2");

        // Bad challenge: done/err at the very next cycle, no enables.
        meas_a(2, 2, t0);
        chk("t3.en", en_a, 0);
        chk("t3.busy", bus_a.busy, 0);
        tick(1);
        chk("t3.en_after", en_a, 0);
        wait_idle("t3");
        chk("t3.err_held", bus_a.err, 1);

        // Start while busy must be ignored.
        meas_a(3, 5, t0);
        wait_cyc(t0 + 499);
        bus_a.start = 1'b1; bus_a.chal_a = 3'd1; bus_a.chal_b = 3'd2;
        tick(1);
        bus_a.start = 1'b0;
        wait_idle("t5");
        tick(5);
        chk("t5.busy_after", bus_a.busy, 0);
        chk("t5.en_after", en_a, 0);

        // Reset mid-COUNT.
        meas_a(5, 3, t0);
        wait_cyc(t0 + 599);
        q_a.delete();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t6.en", en_a, 0);
        chk("t6.busy", bus_a.busy, 0);
        chk("t6.done", bus_a.done, 0);
        chk("t6.response", bus_a.response, 0);
        chk("t6.tie", bus_a.tie, 0);
        chk("t6.err", bus_a.err, 0);
        chk("t6.count_a", bus_a.count_a, 0);
        chk("t6.count_b", bus_a.count_b, 0);
        tick(S + W + 10);
        meas_a(3, 5, t0);
        wait_idle("t6b");

        // Saturation and tie on the 4-bit counter instance.
        e_b.cyc = cyc + 1 + S + W + 1;
        e_b.ca = 16'd15; e_b.cb = 16'd15; e_b.tol = 0;
        e_b.resp = 1'b0; e_b.tie = 1'b1; e_b.err = 1'b0;
        q_b.push_back(e_b);
        bus_b.start = 1'b1; bus_b.chal_a = 3'd1; bus_b.chal_b = 3'd6;
        tick(1);
        bus_b.start = 1'b0;
        chk("t4.en", en_b, 8'h42);
        wait_idle("t4");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/ro_puf_pair_counter.md
# ro_puf_pair_counter

Parametrised ring-oscillator PUF measurement core that replaces free-running single-oscillator use. It gates `N_RO` oscillator inputs, and per request selects one challenge pair `(a, b)`. It enables only those two oscillators, waits a settle period, then counts their rising edges over a fixed clock window and emits one response bit from the count comparison. The block sits between the RO array and the challenge/response controller.

## Interface
- `N_RO`, 8: number of ring oscillators, ≥2.
- `SEL_W`, `$clog2(N_RO)`: challenge index width.
- `CNT_W`, 16: edge-counter width.
- `SETTLE_CYC`, 16: clock cycles the oscillators run before counting, ≥1.
- `WINDOW`, 1024: clock cycles of the counting window, ≥1.
- `clk` in 1: system clock, the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `ro_in` in `N_RO`: raw oscillator outputs, asynchronous to `clk`.
- `ro_enable` out `N_RO`: per-oscillator enable, one-hot-pair while measuring.
- `start` in 1: request a measurement, sampled in IDLE only.
- `chal_a`, `chal_b` in `SEL_W`: oscillator indices, latched with `start`.
- `busy` out 1: measurement in progress.
- `done` out 1: one-cycle pulse when results are valid.
- `response` out 1: `count_a > count_b`.
- `tie` out 1: `count_a == count_b`.
- `err` out 1: bad challenge, either `chal_a == chal_b` or an index ≥ `N_RO`.
- `count_a`, `count_b` out `CNT_W`: edge counts of the last measurement.

## Operation
- Each `ro_in` bit passes through a 2-flop synchroniser, then a third flop for rising-edge detection in the `clk` domain. Oscillator frequency must be below clk/4.
- FSM states: IDLE → SETTLE → COUNT → COMPARE → DONE → IDLE.
- **IDLE**
  - `busy=0`, `ro_enable=0`.
  - On `start=1`, latch `chal_a`/`chal_b` and go to SETTLE.
  - If the latched challenge is bad, go straight to DONE with `err=1`, `response=0`, `tie=0`, and both counts 0.
- **SETTLE**
  - Clear both counters.
  - `ro_enable[a]=ro_enable[b]=1`, all other bits 0.
  - Stay `SETTLE_CYC` cycles.
- **COUNT**
  - Enables held.
  - Each counter increments by 1 on each detected rising edge of its oscillator.
  - Counters saturate at `2^CNT_W-1` with no wrap.
  - Stay `WINDOW` cycles. Edges detected outside COUNT are not counted.
- **COMPARE**
  - `ro_enable` goes to 0.
  - Register `count_a`, `count_b`, `response`, `tie`; `err=0`.
  - Unsigned compare; a tie gives `response=0`, `tie=1`.
- **DONE**
  - `done=1` for exactly one cycle, `busy=0`.
  - `start` is ignored in this cycle. Next state is IDLE.
- `start` is ignored whenever `busy=1`. `chal_*` changes after latching have no effect.
- Result outputs (`response`, `tie`, `err`, `count_*`) hold until the next COMPARE, or until the next DONE for the error path.
- Reset, including mid-measurement:
  - State goes to IDLE and `ro_enable=0` on the next edge.
  - All outputs go to 0 and synchroniser flops clear.
  - No `done` pulse.

## Timing
- Reset values:
  - `ro_enable=0`, `busy=0`, `done=0`.
  - `response=0`, `tie=0`, `err=0`.
  - `count_a=0`, `count_b=0`.
- `start` is sampled at edge T.
- SETTLE covers cycles T+1 … T+`SETTLE_CYC`. `ro_enable` and `busy` are high from T+1.
- COUNT covers T+`SETTLE_CYC`+1 … T+`SETTLE_CYC`+`WINDOW`.
- COMPARE is at T+`SETTLE_CYC`+`WINDOW`+1. `ro_enable` is low from this cycle.
- `done` is high at T+`SETTLE_CYC`+`WINDOW`+2, with results already valid.
- A new `start` is accepted from T+`SETTLE_CYC`+`WINDOW`+3.
- Bad-challenge path: `done` and `err` are high at T+1. `ro_enable` never asserts.
- Count accuracy is ±1 edge, due to the synchroniser and window boundaries.

## Test plan
1. **Normal compare, a slower**
   - Setup: clk 10 ns, `SETTLE_CYC`=16, `WINDOW`=1000. RO3 half-period 250 ns, RO5 half-period 200 ns.
   - Stimulus: `chal_a`=3, `chal_b`=5.
   - Expect: `count_a`=20±1, `count_b`=25±1, `response`=0, `tie`=0.
   - Expect: `done` exactly at start+1018 cycles. `ro_enable`=0b00101000 during SETTLE and COUNT only.
2. **Swapped pair**
   - Stimulus: same setup with `chal_a`=5, `chal_b`=3.
   - Expect: `response`=1, counts swapped.
3. **Bad challenge**
   - Stimulus: `chal_a`=`chal_b`=2.
   - Expect: `done` and `err` high at T+1, `ro_enable` stays 0, counts 0, `response`=0.
4. **Saturation and tie**
   - Stimulus: `CNT_W`=4, both selected ROs with half-period 50 ns.
   - Expect: `count_a`=`count_b`=15, `tie`=1, `response`=0.
5. **Start while busy**
   - Stimulus: pulse `start` with a new challenge at cycle T+500.
   - Expect: ignored; exactly one `done`, with results for the original challenge.
6. **Reset mid-COUNT**
   - Stimulus: assert `rst` for 1 cycle at T+600.
   - Expect: next cycle `ro_enable`=0, `busy`=0, all results 0, no `done`.
   - Follow-up: a fresh `start` then completes normally.
